// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } piso_state_e;

    // Counter width for a count of n values. n <= 1 (including GAP = 0) still
    // needs a one-bit counter so the vector stays legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_reg.sv
// One-entry holding buffer that parks the next word while the current one shifts.
module hold_reg
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // Write fills the entry, read empties it; the parent never does both at once.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (wr_en_i) begin
            data_d = data_in_i;
            full_d = 1'b1;
        end else if (rd_en_i) begin
            full_d = 1'b0;
        end
    end

    // Entry storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_out_o = data_q;
    assign full_o     = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: MSB-first serial stream with optional inter-word gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             frame_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned      CntW     = cnt_width(WIDTH);
    localparam int unsigned      GCntW    = cnt_width(GAP);
    localparam logic [CntW-1:0]  CntLast  = CntW'(WIDTH - 1);
    localparam logic [GCntW-1:0] GCntLast = GCntW'((GAP > 0) ? GAP - 1 : 0);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [GCntW-1:0] gcnt_q, gcnt_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             last_bit;
    logic             reload_edge;
    logic             hold_wr;
    logic             hold_rd;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (hold_wr),
        .data_in_i  (data_i),
        .rd_en_i    (hold_rd),
        .data_out_o (hold_data),
        .full_o     (hold_full)
    );

    // State and datapath registers, synchronous reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: shift/count per state, then the shared reload priority
    // (held word, then a direct accept, else idle) at the end of each word period.
    always_comb begin
        accept      = valid_i && ready_o;
        last_bit    = (state_q == StShift) && (cnt_q == CntLast);
        reload_edge = (last_bit && (GAP == 0)) || ((state_q == StGap) && (gcnt_q == GCntLast));
        hold_rd     = reload_edge && hold_full;
        // Idle accepts and reload-edge accepts bypass the buffer.
        hold_wr     = accept && !reload_edge && (state_q != StIdle);

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        frame_d = 1'b0;
        done_d  = last_bit;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = data_i;
                    cnt_d   = '0;
                    frame_d = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Zero fill leaves shreg clear once a word has fully left,
                // so x_o reads 0 in idle and gap without extra gating.
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        gcnt_d  = '0;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                gcnt_d = gcnt_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reload_edge) begin
            if (hold_full) begin
                shreg_d = hold_data;
                cnt_d   = '0;
                frame_d = 1'b1;
                state_d = StShift;
            end else if (accept) begin
                shreg_d = data_i;
                cnt_d   = '0;
                frame_d = 1'b1;
                state_d = StShift;
            end else begin
                state_d = StIdle;
            end
        end

        // Busy covers the done pulse cycle even when the FSM has already gone idle.
        busy_d = (state_d != StIdle) || done_d;
    end

    // Outputs: registered except ready_o, which tracks the hold buffer.
    always_comb begin
        ready_o = !hold_full && !reset;
        x_o     = shreg_q[WIDTH-1];
        frame_o = frame_q;
        done_o  = done_q;
        busy_o  = busy_q;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that feeds our 4-stage serial-in/parallel-out shift register. Accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB-first on one serial wire, one bit per clock. A downstream left-shifting SIPO therefore holds the word in its original bit order after WIDTH clocks. A one-entry holding register and an optional inter-word gap allow continuous back-to-back streaming.

## Interface
- WIDTH, 4, word width in bits; must be 2 or more.
- GAP, 0, number of idle cycles (x_o=0) inserted after each word; 0 means back-to-back.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_i  input  WIDTH  parallel word; sampled only on accept.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  can accept a word this cycle; equals !hold_full and is forced 0 while reset is high.
- x_o  output  1  serial data; connects to downstream x_i.
- frame_o  output  1  high during the cycle x_o carries the MSB of a word.
- done_o  output  1  one-cycle pulse; downstream SIPO now holds the complete word.
- busy_o  output  1  high when state is not IDLE.

## Operation
- Accept = valid_i && ready_o at a rising edge.
- Storage:
  - shreg[WIDTH-1:0]
  - cnt, which counts 0..WIDTH-1
  - gcnt, which counts 0..GAP-1
  - hold[WIDTH-1:0] with hold_full
- States: IDLE, SHIFT, GAP.
- IDLE:
  - x_o=0, frame_o=0.
  - On accept: shreg<=data_i, cnt<=0, go to SHIFT. The hold register is bypassed.
- SHIFT:
  - x_o=shreg[WIDTH-1]; frame_o=(cnt==0).
  - Each edge: shreg<<=1 (zero fill), cnt++.
  - Accept during SHIFT writes hold, except in the last-bit direct-load case below.
- Last-bit edge (cnt==WIDTH-1):
  - done_o<=1 for the next cycle.
  - If GAP>0: go to GAP with gcnt<=0.
  - Else if hold_full: shreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
  - Else if accept: shreg<=data_i, cnt<=0, stay in SHIFT.
  - Else: go to IDLE.
- GAP:
  - x_o=0, frame_o=0; gcnt++ each edge.
  - At gcnt==GAP-1, apply the same hold / accept / IDLE priority as the last-bit edge.
  - Accept during GAP writes hold when hold is empty.
- Simultaneous events:
  - If hold is full at a reload edge, ready_o was 0, so no accept occurs. Hold drains at that edge and ready_o=1 the next cycle.
  - Hold never overwrites; data_i is ignored whenever ready_o=0.
- Reset (any cycle, including mid-word or mid-gap):
  - state=IDLE, shreg=0, cnt=0, gcnt=0, hold_full=0.
  - Outputs: x_o=0, frame_o=0, done_o=0, busy_o=0, ready_o=0 while reset is high.
  - The partial word and the held word are discarded, with no done_o pulse.
  - ready_o=1 in the first cycle after reset deasserts.

## Timing
- Accept from IDLE at edge E0:
  - MSB on x_o in the cycle after E0.
  - Bit k on x_o in the cycle after edge E0+k.
  - Downstream captures the LSB at edge E0+WIDTH.
  - done_o is high in the cycle after edge E0+WIDTH; busy_o stays high through that cycle.
- Throughput:
  - GAP=0: one word per WIDTH cycles, x_o continuous, frame_o every WIDTH cycles.
  - Otherwise: one word per WIDTH+GAP cycles.
- All outputs come straight from registers except ready_o, which is the inverted hold_full register.

## Structure
- Package piso_pkg holds:
  - the state enum piso_state_e {IDLE, SHIFT, GAP}
  - localparam helpers for counter widths: $clog2(WIDTH), and $clog2(GAP) guarded for GAP=0.
- Sub-module hold_reg: one-entry buffer with ports wr_en, data_in, rd_en, data_out, full.
- The FSM, shift register and counters stay in piso_serializer.

## Test plan
- Single word, WIDTH=4, GAP=0: accept 4'b1011 at E0 → x_o=1,0,1,1 in cycles 1-4; frame_o high in cycle 1 only; done_o high in cycle 5; a chained SIPO shows sr_o=4'b1011 in cycle 5; busy_o falls in cycle 6.
- Back-to-back: valid_i held high with 4'hA, 4'h3, 4'hF → x_o=1010 0011 1111 with no idle bits; done_o pulses every 4 cycles; ready_o drops while hold is full.
- GAP=2: two words 4'h9, 4'h6 → x_o=1001,0,0,0110; frame_o high exactly twice; done_o pulses 6 cycles apart.
- Backpressure: keep valid_i high continuously → no word is dropped or duplicated; each data_i change is seen only on accept edges; after each reload edge ready_o=1 for exactly one cycle.
- Reset mid-word: assert reset after 2 bits of 4'hC with hold full → following cycle x_o=0, busy_o=0, ready_o=0, no done_o; after release a new 4'h5 serializes cleanly as 0101.
- Idle: valid_i=0 for 20 cycles after reset → x_o=0, frame_o=0, done_o=0, ready_o=1 throughout.
